// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit at the consumer end of the EXU next-PC path.
// Holds the architectural PC, fetches the word at pc_out over a valid/ready memory
// interface, presents it to IDU/EXU and advances the PC on the EXU retire handshake.
// Optional build macro: IFU_MISALIGN_CHECK_EN -- halt with illegal_halt instead of
// issuing a request when the PC about to be fetched has pc[1:0] != 0.
module ifu_fetch #(
  parameter int unsigned             ISA_WIDTH      = 32,
  parameter logic [ISA_WIDTH-1:0]    RESET_PC       = ISA_WIDTH'(32'h8000_0000),
  parameter int unsigned             TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ISA_WIDTH-1:0] pc_in,
  input  logic                 pc_w_en,
  output logic [ISA_WIDTH-1:0] pc_out,
  output logic [31:0]          inst,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [ISA_WIDTH-1:0] mem_req_addr,
  input  logic                 mem_resp_valid,
  input  logic [31:0]          mem_resp_data,
  output logic                 fetch_timeout,
  output logic                 illegal_halt
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_t;

  state_t                 r_state;
  logic [ISA_WIDTH-1:0]   r_pc;
  logic [31:0]            r_inst;
  logic                   r_inst_valid;
  logic                   r_mem_req_valid;
  logic                   r_fetch_timeout;
  logic                   r_illegal_halt;
  logic [CNT_W-1:0]       r_wait_cnt;

  logic [CNT_W-1:0]       w_cnt_inc;
  logic                   w_cnt_expired;
  logic                   w_rst_pc_mis;
  logic                   w_pc_in_mis;

  // Wait counter increment and expiry against the configured timeout
  assign w_cnt_inc     = r_wait_cnt + CNT_W'(1);
  assign w_cnt_expired = (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  // Misalignment of the PC that is about to be fetched (reset PC or retired pc_in)
`ifdef IFU_MISALIGN_CHECK_EN
  assign w_rst_pc_mis = |RESET_PC[1:0];
  assign w_pc_in_mis  = |pc_in[1:0];
`else
  assign w_rst_pc_mis = 1'b0;
  assign w_pc_in_mis  = 1'b0;
`endif

  // Fetch FSM: all outputs are registers updated alongside the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_pc            <= RESET_PC;
      r_inst          <= 32'h0;
      r_inst_valid    <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_fetch_timeout <= 1'b0;
      r_illegal_halt  <= 1'b0;
      r_wait_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rst_pc_mis) begin
            r_illegal_halt <= 1'b1;
            r_state        <= S_HALT;
          end else begin
            r_mem_req_valid <= 1'b1;
            r_state         <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_wait_cnt      <= '0;
            r_state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response arriving on the expiring cycle still wins over the timeout
          if (mem_resp_valid) begin
            r_inst       <= mem_resp_data;
            r_inst_valid <= 1'b1;
            r_state      <= S_HOLD;
          end else if (w_cnt_expired) begin
            r_fetch_timeout <= 1'b1;
            r_state         <= S_HALT;
          end else begin
            r_wait_cnt <= w_cnt_inc;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            r_inst_valid <= 1'b0;
            if (pc_w_en) begin
              r_pc <= pc_in;
              if (w_pc_in_mis) begin
                r_illegal_halt <= 1'b1;
                r_state        <= S_HALT;
              end else begin
                r_mem_req_valid <= 1'b1;
                r_state         <= S_REQ;
              end
            end else begin
              r_illegal_halt <= 1'b1;
              r_state        <= S_HALT;
            end
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_mem_req_valid <= 1'b0;
          r_inst_valid    <= 1'b0;
          r_state         <= S_HALT;
        end
      endcase
    end
  end

  assign pc_out        = r_pc;
  assign mem_req_addr  = r_pc;
  assign inst          = r_inst;
  assign inst_valid    = r_inst_valid;
  assign mem_req_valid = r_mem_req_valid;
  assign fetch_timeout = r_fetch_timeout;
  assign illegal_halt  = r_illegal_halt;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed stimulus driven on the falling edge, a procedural
// timeline model of the fetch loop compared on every cycle, plus literal spot checks.
module tb_ifu_fetch;

  localparam int unsigned W = 32;
  localparam int unsigned T = 4;
`ifdef IFU_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] pc_in;
  logic         pc_w_en;
  logic [W-1:0] pc_out;
  logic [31:0]  inst;
  logic         inst_valid;
  logic         inst_ready;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [W-1:0] mem_req_addr;
  logic         mem_resp_valid;
  logic [31:0]  mem_resp_data;
  logic         fetch_timeout;
  logic         illegal_halt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_pc;
  logic [31:0]  exp_inst;
  logic         exp_valid;
  logic         exp_req;
  logic         exp_to;
  logic         exp_ih;

  ifu_fetch #(
    .ISA_WIDTH      (W),
    .RESET_PC       (32'h8000_0000),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .pc_w_en        (pc_w_en),
    .pc_out         (pc_out),
    .inst           (inst),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .fetch_timeout  (fetch_timeout),
    .illegal_halt   (illegal_halt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: walks the fetch loop one protocol phase at a time
  initial begin : model
    bit live;
    bit got;
    int waited;
    forever begin
      exp_pc    = 32'h8000_0000;
      exp_inst  = 32'h0;
      exp_valid = 1'b0;
      exp_req   = 1'b0;
      exp_to    = 1'b0;
      exp_ih    = 1'b0;
      @(posedge clk);
      while (!rst) @(posedge clk);
      live = 1'b1;
      while (live) begin
        if (MIS_EN && (exp_pc[1:0] != 2'b00)) begin
          exp_ih = 1'b1;
          break;
        end
        exp_req = 1'b1;
        do begin
          @(posedge clk);
          live = rst;
        end while (live && !mem_req_ready);
        if (!live) break;
        exp_req = 1'b0;
        got     = 1'b0;
        waited  = 0;
        while (live && !got && waited < int'(T)) begin
          @(posedge clk);
          live = rst;
          if (live) begin
            if (mem_resp_valid) begin
              got      = 1'b1;
              exp_inst = mem_resp_data;
            end else begin
              waited++;
            end
          end
        end
        if (!live) break;
        if (!got) begin
          exp_to = 1'b1;
          break;
        end
        exp_valid = 1'b1;
        do begin
          @(posedge clk);
          live = rst;
        end while (live && !inst_ready);
        if (!live) break;
        exp_valid = 1'b0;
        if (!pc_w_en) begin
          exp_ih = 1'b1;
          break;
        end
        exp_pc = pc_in;
      end
      while (rst) @(posedge clk);
    end
  end

  // Cycle compare of DUT outputs against the model, just after each rising edge
  initial begin : cmp
    forever begin
      @(posedge clk);
      #1;
      check("pc_out", pc_out, exp_pc);
      check("inst", inst, exp_inst);
      check("inst_valid", 32'(inst_valid), 32'(exp_valid));
      check("mem_req_valid", 32'(mem_req_valid), 32'(exp_req));
      if (exp_req) check("mem_req_addr", mem_req_addr, exp_pc);
      check("fetch_timeout", 32'(fetch_timeout), 32'(exp_to));
      check("illegal_halt", 32'(illegal_halt), 32'(exp_ih));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Directed stimulus with literal spot checks
  initial begin : stim
    pc_in          = '0;
    pc_w_en        = 1'b0;
    inst_ready     = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    cyc(2);
    check("rst_pc", pc_out, 32'h8000_0000);
    check("rst_req", 32'(mem_req_valid), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_to", 32'(fetch_timeout), 32'd0);
    check("rst_ih", 32'(illegal_halt), 32'd0);

    // 1: first fetch, minimum latency
    rst = 1'b1;
    cyc(1);
    check("t1_req", 32'(mem_req_valid), 32'd1);
    check("t1_addr", mem_req_addr, 32'h8000_0000);
    mem_req_ready = 1'b1;
    cyc(1);
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_0413;
    check("t1_req_drop", 32'(mem_req_valid), 32'd0);
    check("t1_valid_n1", 32'(inst_valid), 32'd0);
    cyc(1);
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    check("t1_valid_n2", 32'(inst_valid), 32'd1);
    check("t1_inst", inst, 32'h0000_0413);

    // 2: stall 5 cycles, then retire to 0x80000010
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("t2_hold_inst", inst, 32'h0000_0413);
      check("t2_hold_pc", pc_out, 32'h8000_0000);
      check("t2_hold_valid", 32'(inst_valid), 32'd1);
    end
    inst_ready = 1'b1;
    pc_w_en    = 1'b1;
    pc_in      = 32'h8000_0010;
    cyc(1);
    inst_ready = 1'b0;
    check("t2_pc", pc_out, 32'h8000_0010);
    check("t2_req", 32'(mem_req_valid), 32'd1);
    check("t2_addr", mem_req_addr, 32'h8000_0010);
    check("t2_valid", 32'(inst_valid), 32'd0);

    // 3: memory not ready for 3 cycles; pc_w_en outside HOLD is ignored
    pc_in = 32'hDEAD_BEE0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("t3_req", 32'(mem_req_valid), 32'd1);
      check("t3_addr", mem_req_addr, 32'h8000_0010);
    end
    pc_w_en       = 1'b0;
    mem_req_ready = 1'b1;
    cyc(1);
    mem_req_ready = 1'b0;
    check("t3_wait_req", 32'(mem_req_valid), 32'd0);

    // 4b: response on the last allowed WAIT cycle wins over the timeout
    cyc(3);
    check("t4b_to_pre", 32'(fetch_timeout), 32'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0010_0093;
    cyc(1);
    mem_resp_valid = 1'b0;
    check("t4b_valid", 32'(inst_valid), 32'd1);
    check("t4b_inst", inst, 32'h0010_0093);
    check("t4b_to", 32'(fetch_timeout), 32'd0);

    // 4a: no response at all -> timeout after 4 WAIT cycles
    inst_ready = 1'b1;
    pc_w_en    = 1'b1;
    pc_in      = 32'h8000_0020;
    cyc(1);
    inst_ready = 1'b0;
    pc_w_en    = 1'b0;
    check("t4_addr", mem_req_addr, 32'h8000_0020);
    mem_req_ready = 1'b1;
    cyc(1);
    mem_req_ready = 1'b0;
    cyc(3);
    check("t4_to_pre", 32'(fetch_timeout), 32'd0);
    cyc(1);
    check("t4_to", 32'(fetch_timeout), 32'd1);
    check("t4_req", 32'(mem_req_valid), 32'd0);
    mem_resp_valid = 1'b1;
    mem_req_ready  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("t4_halt_req", 32'(mem_req_valid), 32'd0);
      check("t4_halt_valid", 32'(inst_valid), 32'd0);
    end
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b0;

    // 5: retire without pc_w_en -> illegal_halt
    rst = 1'b0;
    cyc(1);
    check("t5_rst_to", 32'(fetch_timeout), 32'd0);
    check("t5_rst_pc", pc_out, 32'h8000_0000);
    rst = 1'b1;
    cyc(1);
    mem_req_ready = 1'b1;
    cyc(1);
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_0013;
    cyc(1);
    mem_resp_valid = 1'b0;
    inst_ready     = 1'b1;
    pc_w_en        = 1'b0;
    pc_in          = 32'h8000_0040;
    cyc(1);
    inst_ready = 1'b0;
    check("t5_ih", 32'(illegal_halt), 32'd1);
    check("t5_pc", pc_out, 32'h8000_0000);
    check("t5_valid", 32'(inst_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("t5_no_req", 32'(mem_req_valid), 32'd0);
    end

    // 6: reset mid-WAIT, stale response afterwards is ignored
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    mem_req_ready = 1'b1;
    cyc(1);
    mem_req_ready = 1'b0;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    check("t6_rst_valid", 32'(inst_valid), 32'd0);
    check("t6_rst_req", 32'(mem_req_valid), 32'd0);
    check("t6_rst_ih", 32'(illegal_halt), 32'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hBAD0_0BAD;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    check("t6_req", 32'(mem_req_valid), 32'd1);
    check("t6_addr", mem_req_addr, 32'h8000_0000);
    check("t6_stale_valid", 32'(inst_valid), 32'd0);
    check("t6_stale_inst", inst, 32'h0);
    cyc(1);
    check("t6_stale_valid2", 32'(inst_valid), 32'd0);
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    cyc(1);
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0040_0093;
    cyc(1);
    mem_resp_valid = 1'b0;
    check("t6_valid", 32'(inst_valid), 32'd1);
    check("t6_inst", inst, 32'h0040_0093);

    // 7: retire to a misaligned PC
    inst_ready = 1'b1;
    pc_w_en    = 1'b1;
    pc_in      = 32'h8000_0002;
    cyc(1);
    inst_ready = 1'b0;
    pc_w_en    = 1'b0;
    check("t7_pc", pc_out, 32'h8000_0002);
`ifdef IFU_MISALIGN_CHECK_EN
    check("t7_ih", 32'(illegal_halt), 32'd1);
    check("t7_to", 32'(fetch_timeout), 32'd0);
    check("t7_req", 32'(mem_req_valid), 32'd0);
    cyc(2);
    check("t7_no_req", 32'(mem_req_valid), 32'd0);
`else
    check("t7_req", 32'(mem_req_valid), 32'd1);
    check("t7_addr", mem_req_addr, 32'h8000_0002);
    check("t7_ih", 32'(illegal_halt), 32'd0);
    mem_req_ready = 1'b1;
    cyc(1);
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_8067;
    cyc(1);
    mem_resp_valid = 1'b0;
    check("t7_inst", inst, 32'h0000_8067);
`endif
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
